// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite mover: direction codes, per-axis motion decode
// and the 8x8 ball bitmap.
package sprite_pkg;

   localparam logic [2:0] DIR_N  = 3'd0;
   localparam logic [2:0] DIR_NE = 3'd1;
   localparam logic [2:0] DIR_E  = 3'd2;
   localparam logic [2:0] DIR_SE = 3'd3;
   localparam logic [2:0] DIR_S  = 3'd4;
   localparam logic [2:0] DIR_SW = 3'd5;
   localparam logic [2:0] DIR_W  = 3'd6;
   localparam logic [2:0] DIR_NW = 3'd7;

   typedef struct packed {
      logic x_pos;
      logic x_neg;
      logic y_pos;
      logic y_neg;
   } motion_t;

   // Screen y grows downward, so "north" is a negative y step.
   function automatic motion_t decode_motion(input logic [2:0] d);
      motion_t m;
      m = '0;
      m.x_pos = (d == DIR_NE) || (d == DIR_E) || (d == DIR_SE);
      m.x_neg = (d == DIR_SW) || (d == DIR_W) || (d == DIR_NW);
      m.y_neg = (d == DIR_NW) || (d == DIR_N) || (d == DIR_NE);
      m.y_pos = (d == DIR_SE) || (d == DIR_S) || (d == DIR_SW);
      return m;
   endfunction

   // Row 0 is the top row; bit 0 of each row is its leftmost pixel.
   localparam logic [0:7][7:0] BALL_ROM = {
      8'h3C, 8'h7E, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h7E, 8'h3C
   };

endpackage

// File: rtl/sprite_dir_fsm.sv
// Travel-direction register for the sprite: edge-detected turn buttons plus
// edge reflections requested by the position logic.
module sprite_dir_fsm
   import sprite_pkg::*;
#(
   parameter logic [2:0] INIT_DIR = DIR_E
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       turn_r,
   input  logic       turn_l,
   input  logic       reflect_x,
   input  logic       reflect_y,
   output logic [2:0] dir
);

   logic       r_q;
   logic       r_qq;
   logic       l_q;
   logic       l_qq;
   logic       edge_r;
   logic       edge_l;
   logic [2:0] reflected;
   logic [2:0] dir_next;

   // Two-stage capture so a held button gives a single one-cycle edge.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_q  <= 1'b0;
         r_qq <= 1'b0;
         l_q  <= 1'b0;
         l_qq <= 1'b0;
      end else begin
         r_q  <= turn_r;
         r_qq <= r_q;
         l_q  <= turn_l;
         l_qq <= l_q;
      end
   end

   assign edge_r = r_q & ~r_qq;
   assign edge_l = l_q & ~l_qq;

   // Reflections take priority and swallow any turn arriving in the same cycle.
   always_comb begin
      reflected = dir;
      if (reflect_x)
         reflected = 3'd0 - reflected;
      if (reflect_y)
         reflected = 3'd4 - reflected;

      dir_next = dir;
      if (reflect_x || reflect_y)
         dir_next = reflected;
      else if (edge_r && !edge_l)
         dir_next = dir + 3'd1;
      else if (edge_l && !edge_r)
         dir_next = dir - 3'd1;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         dir <= INIT_DIR;
      else
         dir <= dir_next;
   end

endmodule

// File: rtl/sprite_mover.sv
// Moving round sprite for the VGA pipeline. Define SPRITE_MOVER_BOUNCE_EN to clamp
// and reflect at screen edges; otherwise the sprite wraps around.
module sprite_mover
   import sprite_pkg::*;
#(
   parameter int          MAX_X    = 640,
   parameter int          MAX_Y    = 480,
   parameter int          SIZE     = 8,
   parameter int          INIT_X   = 100,
   parameter int          INIT_Y   = 150,
   parameter int          INIT_DIR = 2,
   parameter int          STEP     = 1,
   parameter logic [11:0] COLOR    = 12'h1AF
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        refr_tick,
   input  logic        turn_r,
   input  logic        turn_l,
   input  logic [9:0]  x,
   input  logic [9:0]  y,
   output logic [11:0] sprite_rgb,
   output logic        sprite_on,
   output logic [9:0]  pos_x,
   output logic [9:0]  pos_y,
   output logic [2:0]  dir
);

   localparam int LIM_X = MAX_X - SIZE;
   localparam int LIM_Y = MAX_Y - SIZE;
   localparam int SHIFT = $clog2(SIZE / 8);

   motion_t    mv;
   logic [10:0] sum_x;
   logic [10:0] sum_y;
   logic       ovf_x;
   logic       ovf_y;
   logic [9:0] next_x;
   logic [9:0] next_y;
   logic       reflect_x;
   logic       reflect_y;

   assign mv    = decode_motion(dir);
   assign sum_x = {1'b0, pos_x} + 11'(STEP);
   assign sum_y = {1'b0, pos_y} + 11'(STEP);

   // An axis overflows when the next step would leave 0..limit in its direction of travel.
   assign ovf_x = (mv.x_pos && (sum_x > 11'(LIM_X))) || (mv.x_neg && (pos_x < 10'(STEP)));
   assign ovf_y = (mv.y_pos && (sum_y > 11'(LIM_Y))) || (mv.y_neg && (pos_y < 10'(STEP)));

   always_comb begin
      next_x = pos_x;
      if (mv.x_pos) begin
         if (ovf_x)
`ifdef SPRITE_MOVER_BOUNCE_EN
            next_x = 10'(LIM_X);
`else
            next_x = '0;
`endif
         else
            next_x = sum_x[9:0];
      end else if (mv.x_neg) begin
         if (ovf_x)
`ifdef SPRITE_MOVER_BOUNCE_EN
            next_x = '0;
`else
            next_x = 10'(LIM_X);
`endif
         else
            next_x = pos_x - 10'(STEP);
      end
   end

   always_comb begin
      next_y = pos_y;
      if (mv.y_pos) begin
         if (ovf_y)
`ifdef SPRITE_MOVER_BOUNCE_EN
            next_y = 10'(LIM_Y);
`else
            next_y = '0;
`endif
         else
            next_y = sum_y[9:0];
      end else if (mv.y_neg) begin
         if (ovf_y)
`ifdef SPRITE_MOVER_BOUNCE_EN
            next_y = '0;
`else
            next_y = 10'(LIM_Y);
`endif
         else
            next_y = pos_y - 10'(STEP);
      end
   end

`ifdef SPRITE_MOVER_BOUNCE_EN
   assign reflect_x = refr_tick & ovf_x;
   assign reflect_y = refr_tick & ovf_y;
`else
   assign reflect_x = 1'b0;
   assign reflect_y = 1'b0;
`endif

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         pos_x <= 10'(INIT_X);
         pos_y <= 10'(INIT_Y);
      end else if (refr_tick) begin
         pos_x <= next_x;
         pos_y <= next_y;
      end
   end

   sprite_dir_fsm #(
      .INIT_DIR (3'(INIT_DIR))
   ) u_dir (
      .clk       (clk),
      .rstn      (rstn),
      .turn_r    (turn_r),
      .turn_l    (turn_l),
      .reflect_x (reflect_x),
      .reflect_y (reflect_y),
      .dir       (dir)
   );

   logic [10:0] end_x;
   logic [10:0] end_y;
   logic        in_x;
   logic        in_y;
   logic [9:0]  off_x;
   logic [9:0]  off_y;
   logic [2:0]  col;
   logic [2:0]  row;

   assign end_x = {1'b0, pos_x} + 11'(SIZE);
   assign end_y = {1'b0, pos_y} + 11'(SIZE);
   assign in_x  = (x >= pos_x) && ({1'b0, x} < end_x);
   assign in_y  = (y >= pos_y) && ({1'b0, y} < end_y);

   // Offsets are only meaningful inside the box; scaling shrinks them back to ROM coordinates.
   assign off_x = x - pos_x;
   assign off_y = y - pos_y;
   assign col   = 3'(off_x >> SHIFT);
   assign row   = 3'(off_y >> SHIFT);

   assign sprite_on  = in_x & in_y & BALL_ROM[row][col];
   assign sprite_rgb = COLOR;

endmodule

// File: tb/tb_sprite_mover.sv
// Directed testbench for sprite_mover: reset, motion, turns, pixel test, edge
// handling (wrap or bounce, following SPRITE_MOVER_BOUNCE_EN) and async reset.
module tb_sprite_mover;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       refr_tick = 1'b0;
   logic       turn_r = 1'b0;
   logic       turn_l = 1'b0;
   logic       nil = 1'b0;
   logic [9:0] x = '0;
   logic [9:0] y = '0;

   logic [11:0] m_rgb, s_rgb, e_rgb, c_rgb;
   logic        m_on, s_on, e_on, c_on;
   logic [9:0]  m_px, m_py, s_px, s_py, e_px, e_py, c_px, c_py;
   logic [2:0]  m_dir, s_dir, e_dir, c_dir;

   int total = 0;
   int bad = 0;

`ifdef SPRITE_MOVER_BOUNCE_EN
   localparam int E_X = 632, E_DIR = 1;
   localparam int C_DIR = 7;
`else
   localparam int E_X = 631, E_DIR = 2;
   localparam int C_DIR = 6;
`endif

   always #5 clk = ~clk;

   sprite_mover u_main (
      .clk(clk), .rstn(rstn), .refr_tick(refr_tick), .turn_r(turn_r), .turn_l(turn_l),
      .x(x), .y(y), .sprite_rgb(m_rgb), .sprite_on(m_on),
      .pos_x(m_px), .pos_y(m_py), .dir(m_dir)
   );

   sprite_mover #(.SIZE(16)) u_big (
      .clk(clk), .rstn(rstn), .refr_tick(refr_tick), .turn_r(nil), .turn_l(nil),
      .x(x), .y(y), .sprite_rgb(s_rgb), .sprite_on(s_on),
      .pos_x(s_px), .pos_y(s_py), .dir(s_dir)
   );

   sprite_mover #(.INIT_X(E_X), .INIT_Y(150), .INIT_DIR(E_DIR)) u_edge (
      .clk(clk), .rstn(rstn), .refr_tick(refr_tick), .turn_r(nil), .turn_l(nil),
      .x(x), .y(y), .sprite_rgb(e_rgb), .sprite_on(e_on),
      .pos_x(e_px), .pos_y(e_py), .dir(e_dir)
   );

   sprite_mover #(.INIT_X(0), .INIT_Y(0), .INIT_DIR(C_DIR)) u_corner (
      .clk(clk), .rstn(rstn), .refr_tick(refr_tick), .turn_r(nil), .turn_l(nil),
      .x(x), .y(y), .sprite_rgb(c_rgb), .sprite_on(c_on),
      .pos_x(c_px), .pos_y(c_py), .dir(c_dir)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      refr_tick = 1'b0;
      turn_r = 1'b0;
      turn_l = 1'b0;
      step();
      step();
      rstn = 1'b1;
      step();
   endtask

   task automatic tick();
      refr_tick = 1'b1;
      step();
      refr_tick = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      total++; if (m_px !== 10'd100) begin bad++; $display("[TB] FAIL reset_pos_x got=%0d want=100", m_px); end
      total++; if (m_py !== 10'd150) begin bad++; $display("[TB] FAIL reset_pos_y got=%0d want=150", m_py); end
      total++; if (m_dir !== 3'd2) begin bad++; $display("[TB] FAIL reset_dir got=%0d want=2", m_dir); end
      total++; if (m_rgb !== 12'h1AF) begin bad++; $display("[TB] FAIL rgb got=%h want=1af", m_rgb); end
   endtask

   task automatic test_tick();
      step();
      total++; if (m_px !== 10'd100) begin bad++; $display("[TB] FAIL idle_pos_x got=%0d want=100", m_px); end
      tick();
      total++; if (m_px !== 10'd101) begin bad++; $display("[TB] FAIL tick_pos_x got=%0d want=101", m_px); end
      total++; if (m_py !== 10'd150) begin bad++; $display("[TB] FAIL tick_pos_y got=%0d want=150", m_py); end
      total++; if (m_dir !== 3'd2) begin bad++; $display("[TB] FAIL tick_dir got=%0d want=2", m_dir); end
   endtask

   task automatic test_turn();
      do_reset();
      turn_r = 1'b1;
      step();
      total++; if (m_dir !== 3'd2) begin bad++; $display("[TB] FAIL turn_latency got=%0d want=2", m_dir); end
      step();
      total++; if (m_dir !== 3'd3) begin bad++; $display("[TB] FAIL turn_r got=%0d want=3", m_dir); end
      repeat (8) step();
      total++; if (m_dir !== 3'd3) begin bad++; $display("[TB] FAIL turn_r_held got=%0d want=3", m_dir); end
      turn_r = 1'b0;
      step();
      step();
      turn_l = 1'b1;
      step();
      step();
      total++; if (m_dir !== 3'd2) begin bad++; $display("[TB] FAIL turn_l got=%0d want=2", m_dir); end
      turn_l = 1'b0;
      step();
      step();
      turn_r = 1'b1;
      turn_l = 1'b1;
      repeat (3) step();
      total++; if (m_dir !== 3'd2) begin bad++; $display("[TB] FAIL turn_both got=%0d want=2", m_dir); end
      turn_r = 1'b0;
      turn_l = 1'b0;
      step();
   endtask

   task automatic test_pixel();
      do_reset();
      x = 10'd100; y = 10'd150; #1;
      total++; if (m_on !== 1'b0) begin bad++; $display("[TB] FAIL pix_100_150 got=%0b want=0", m_on); end
      total++; if (s_on !== 1'b0) begin bad++; $display("[TB] FAIL big_100_150 got=%0b want=0", s_on); end
      x = 10'd103; #1;
      total++; if (m_on !== 1'b1) begin bad++; $display("[TB] FAIL pix_103_150 got=%0b want=1", m_on); end
      x = 10'd108; #1;
      total++; if (m_on !== 1'b0) begin bad++; $display("[TB] FAIL pix_108_150 got=%0b want=0", m_on); end
      x = 10'd100; y = 10'd152; #1;
      total++; if (m_on !== 1'b1) begin bad++; $display("[TB] FAIL pix_100_152 got=%0b want=1", m_on); end
      x = 10'd103; y = 10'd157; #1;
      total++; if (m_on !== 1'b1) begin bad++; $display("[TB] FAIL pix_103_157 got=%0b want=1", m_on); end
      y = 10'd158; #1;
      total++; if (m_on !== 1'b0) begin bad++; $display("[TB] FAIL pix_103_158 got=%0b want=0", m_on); end
      x = 10'd102; y = 10'd150; #1;
      total++; if (s_on !== 1'b0) begin bad++; $display("[TB] FAIL big_102_150 got=%0b want=0", s_on); end
      x = 10'd106; #1;
      total++; if (s_on !== 1'b1) begin bad++; $display("[TB] FAIL big_106_150 got=%0b want=1", s_on); end
      x = 10'd115; y = 10'd155; #1;
      total++; if (s_on !== 1'b1) begin bad++; $display("[TB] FAIL big_115_155 got=%0b want=1", s_on); end
      x = 10'd116; #1;
      total++; if (s_on !== 1'b0) begin bad++; $display("[TB] FAIL big_116_155 got=%0b want=0", s_on); end
   endtask

   task automatic test_edges();
      do_reset();
      tick();
`ifdef SPRITE_MOVER_BOUNCE_EN
      total++; if (e_px !== 10'd632) begin bad++; $display("[TB] FAIL bounce_x1 got=%0d want=632", e_px); end
      total++; if (e_py !== 10'd149) begin bad++; $display("[TB] FAIL bounce_y1 got=%0d want=149", e_py); end
      total++; if (e_dir !== 3'd7) begin bad++; $display("[TB] FAIL bounce_dir1 got=%0d want=7", e_dir); end
      total++; if (c_px !== 10'd0 || c_py !== 10'd0) begin bad++; $display("[TB] FAIL corner_pos got=%0d,%0d want=0,0", c_px, c_py); end
      total++; if (c_dir !== 3'd3) begin bad++; $display("[TB] FAIL corner_dir got=%0d want=3", c_dir); end
      tick();
      total++; if (e_px !== 10'd631 || e_py !== 10'd148) begin bad++; $display("[TB] FAIL bounce_pos2 got=%0d,%0d want=631,148", e_px, e_py); end
      total++; if (c_px !== 10'd1 || c_py !== 10'd1) begin bad++; $display("[TB] FAIL corner_pos2 got=%0d,%0d want=1,1", c_px, c_py); end
`else
      total++; if (e_px !== 10'd632) begin bad++; $display("[TB] FAIL wrap_x1 got=%0d want=632", e_px); end
      total++; if (c_px !== 10'd632) begin bad++; $display("[TB] FAIL wrap_west got=%0d want=632", c_px); end
      total++; if (c_py !== 10'd0) begin bad++; $display("[TB] FAIL wrap_west_y got=%0d want=0", c_py); end
      tick();
      total++; if (e_px !== 10'd0) begin bad++; $display("[TB] FAIL wrap_x2 got=%0d want=0", e_px); end
      total++; if (e_py !== 10'd150) begin bad++; $display("[TB] FAIL wrap_y2 got=%0d want=150", e_py); end
      total++; if (e_dir !== 3'd2) begin bad++; $display("[TB] FAIL wrap_dir got=%0d want=2", e_dir); end
      total++; if (c_px !== 10'd631) begin bad++; $display("[TB] FAIL wrap_west2 got=%0d want=631", c_px); end
`endif
   endtask

   task automatic test_async_reset();
      do_reset();
      refr_tick = 1'b1;
      repeat (5) step();
      total++; if (m_px !== 10'd105) begin bad++; $display("[TB] FAIL run_pos_x got=%0d want=105", m_px); end
      #3;
      rstn = 1'b0;
      #1;
      total++; if (m_px !== 10'd100 || m_py !== 10'd150) begin bad++; $display("[TB] FAIL async_pos got=%0d,%0d want=100,150", m_px, m_py); end
      total++; if (m_dir !== 3'd2) begin bad++; $display("[TB] FAIL async_dir got=%0d want=2", m_dir); end
      step();
      refr_tick = 1'b0;
      rstn = 1'b1;
      step();
      total++; if (m_px !== 10'd100) begin bad++; $display("[TB] FAIL post_reset_x got=%0d want=100", m_px); end
      tick();
      total++; if (m_px !== 10'd101) begin bad++; $display("[TB] FAIL resume_x got=%0d want=101", m_px); end
   endtask

   initial begin
      test_reset();
      test_tick();
      test_turn();
      test_pixel();
      test_edges();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sprite_mover.md
# sprite_mover

Parametrised moving-sprite generator for the VGA pixel pipeline. It holds a sprite position and one of eight travel directions, and steers the direction from edge-detected turn buttons. On each frame refresh tick it advances the position, either wrapping or bouncing at the screen edges. For every scanned pixel it reports whether that pixel lies on the sprite's round bitmap, and gives the sprite colour for the RGB mux.

## Interface
- MAX_X, 640: horizontal resolution in pixels.
- MAX_Y, 480: vertical resolution in pixels.
- SIZE, 8: sprite edge in pixels. Must be 8, 16 or 32.
- INIT_X, 100: reset x position (top-left corner).
- INIT_Y, 150: reset y position (top-left corner).
- INIT_DIR, 2: reset direction code (E).
- STEP, 1: pixels moved per axis per tick, 1..SIZE.
- COLOR, 12'h1AF: sprite RGB444 colour.
- clk  in  1  pixel/system clock.
- rstn  in  1  reset, asynchronous, active-low.
- refr_tick  in  1  one-cycle pulse per frame.
- turn_r  in  1  raw level, clockwise turn request.
- turn_l  in  1  raw level, counter-clockwise turn request.
- x  in  10  current scan column.
- y  in  10  current scan row.
- sprite_rgb  out  12  constant COLOR.
- sprite_on  out  1  current pixel is an opaque sprite pixel.
- pos_x  out  10  registered sprite x.
- pos_y  out  10  registered sprite y.
- dir  out  3  registered direction code.

## Operation
- Direction codes run clockwise: 0 N, 1 NE, 2 E, 3 SE, 4 S, 5 SW, 6 W, 7 NW.
- Per-axis motion from dir: dx is +1 for {1,2,3}, −1 for {5,6,7}, 0 otherwise. dy is −1 for {7,0,1}, +1 for {3,4,5}, 0 otherwise.
- turn_r and turn_l are each registered and rising-edge detected. A held level yields exactly one turn.
  - turn_r edge: dir ← dir+1 mod 8.
  - turn_l edge: dir ← dir−1 mod 8.
  - Both edges in the same cycle: no change.
- Position update happens only on a cycle with refr_tick=1. It uses the dir value registered before that edge. Axes are evaluated independently. The legal range is 0..MAX_X−SIZE for x and 0..MAX_Y−SIZE for y.
- Wrap mode, positive axis: pos+STEP > limit gives 0, else pos+STEP.
- Wrap mode, negative axis: pos < STEP gives limit, else pos−STEP.
- Bounce mode: an overflowing axis clamps to limit or 0 and reflects dir.
  - x reflect: dir ← (8−dir) mod 8.
  - y reflect: dir ← (4−dir) mod 8.
  - Corner: both reflections apply, which reverses dir by 4.
- If a reflection and a turn edge coincide, the reflection wins and the turn is dropped.
- Pixel test: inside = pos_x ≤ x < pos_x+SIZE and pos_y ≤ y < pos_y+SIZE.
- Bitmap is an 8×8 ROM: rows 3C,7E,FF,FF,FF,FF,7E,3C. Bit index is the column offset, LSB at left.
- The ROM is scaled by SIZE/8 through pixel replication:
  - row = (y−pos_y)>>log2(SIZE/8);
  - col = (x−pos_x)>>log2(SIZE/8).
- sprite_on = inside & rom[row][col].

## Timing
- Reset values: pos_x=INIT_X, pos_y=INIT_Y, dir=INIT_DIR, edge-detect registers 0. sprite_rgb=COLOR, and sprite_on follows combinationally.
- Turn latency: dir changes on the second clk edge after turn_r rises (one cycle for registering, one for the update).
- Position changes on the clk edge sampling refr_tick=1. New pos_x, pos_y and dir are visible the following cycle.
- sprite_on is combinational from x, y and the registered position, with zero added latency.
- Reset asserted mid-frame immediately restores all reset values. Motion resumes at the first refr_tick after release.

## Configuration
- SPRITE_MOVER_BOUNCE_EN defined: bounce mode (clamp and reflect).
- Not defined: wrap mode. dir changes only by turn edges.

## Structure
- Package sprite_pkg holds:
  - the direction localparams DIR_N … DIR_NW;
  - the dx/dy decode function;
  - the 8×8 ball ROM constant.
- One sub-module, sprite_dir_fsm, contains the turn edge detection, the dir register and the reflect inputs. The position counters and pixel test stay in the top module.

## Test plan
- Reset with defaults → pos=(100,150), dir=2. One refr_tick → pos_x=101, pos_y=150.
- turn_r held high 10 cycles → dir 2→3 exactly once. turn_r and turn_l rising together → dir unchanged.
- Wrap build: INIT_X=631, dir E. Tick → pos_x=632. Next tick → pos_x=0. dir W at pos_x=0 → 632.
- Bounce build: pos_x=632, dir NE, tick → pos_x=632, dir=7 (NW), pos_y decremented by 1. Corner at (0,0) with dir NW → dir=3 (SE).
- pos=(100,150), SIZE=8: (x,y)=(100,150) → sprite_on=0, (103,150) → 1, (108,150) → 0. SIZE=16: (102,150) → 0, (106,150) → 1.
- rstn pulsed low during continuous ticks → pos=(100,150) and dir=2 within the same cycle, asynchronously.
